// File: rtl/pwl_activation_pipe_if.sv
// Stream-in / stream-out / table-write bundle for pwl_activation_pipe.
// master drives samples and table writes; slave is the activation unit.
interface pwl_activation_pipe_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int SEL_W  = 1
);
    logic              i_valid;
    logic              i_ready;
    logic [DATA_W-1:0] i_data;
    logic [SEL_W-1:0]  i_sel;
    logic              o_valid;
    logic              o_ready;
    logic [DATA_W-1:0] o_data;
    logic [SEL_W-1:0]  o_sel;
    logic              tbl_we;
    logic [SEL_W-1:0]  tbl_sel;
    logic [ADDR_W:0]   tbl_addr;
    logic [DATA_W-1:0] tbl_data;
    logic [15:0]       o_count;

    modport master (
        output i_valid, i_data, i_sel, o_ready, tbl_we, tbl_sel, tbl_addr, tbl_data,
        input  i_ready, o_valid, o_data, o_sel, o_count
    );

    modport slave (
        input  i_valid, i_data, i_sel, o_ready, tbl_we, tbl_sel, tbl_addr, tbl_data,
        output i_ready, o_valid, o_data, o_sel, o_count
    );
endinterface

// File: rtl/pwl_activation_pipe.sv
// 3-stage piecewise-linear activation with N_TBL writable tables and valid/ready backpressure.
// Optional macro PWL_CNT_EN enables the 16-bit accepted-output counter on o_count.
module pwl_activation_pipe #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int N_TBL  = 2,
    parameter int SEL_W  = 1
) (
    input  logic               clk,
    input  logic               rst,
    pwl_activation_pipe_if.slave bus
);
    localparam int FRAC_W = DATA_W - ADDR_W;
    localparam int NENT   = (1 << ADDR_W) + 1;
    localparam int PW     = DATA_W + FRAC_W + 2;

    logic signed [DATA_W-1:0] tbl_q [N_TBL][NENT];

    logic [3:1]               vld_q;
    logic signed [DATA_W-1:0] s1_base_q, s1_next_q;
    logic [FRAC_W-1:0]        s1_rem_q;
    logic [SEL_W-1:0]         s1_sel_q;
    logic signed [DATA_W-1:0] s2_base_q;
    logic signed [PW-1:0]     s2_prod_q;
    logic [SEL_W-1:0]         s2_sel_q;
    logic [DATA_W-1:0]        o_data_q;
    logic [SEL_W-1:0]         o_sel_q;

    logic                     adv, xfer, wr_ok;
    logic [ADDR_W-1:0]        idx;
    logic [ADDR_W:0]          idx_b, idx_n;
    logic [SEL_W-1:0]         rd_sel;
    logic signed [DATA_W:0]   diff_d;
    logic signed [PW-1:0]     prod_d;
    logic signed [DATA_W-1:0] y_d;

    assign adv  = !vld_q[3] || bus.o_ready;
    assign xfer = bus.i_valid && adv;

    assign wr_ok = bus.tbl_we && (32'(bus.tbl_sel) < N_TBL) && (32'(bus.tbl_addr) < NENT);

    // Negative z lands in the upper half of the table because idx is unsigned.
    assign idx    = bus.i_data[DATA_W-1:FRAC_W];
    assign idx_b  = {1'b0, idx};
    assign idx_n  = idx_b + 1'b1;
    assign rd_sel = (32'(bus.i_sel) < N_TBL) ? bus.i_sel : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int t = 0; t < N_TBL; t++)
                for (int e = 0; e < NENT; e++)
                    tbl_q[t][e] <= '0;
        end else if (wr_ok) begin
            tbl_q[bus.tbl_sel][bus.tbl_addr] <= bus.tbl_data;
        end
    end

    always_comb begin
        diff_d = {s1_next_q[DATA_W-1], s1_next_q} - {s1_base_q[DATA_W-1], s1_base_q};
        prod_d = PW'(diff_d) * PW'($signed({1'b0, s1_rem_q}));
        // Result is bounded by base and next, so modular truncation is exact.
        y_d    = s2_base_q + DATA_W'(s2_prod_q >>> FRAC_W);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q     <= '0;
            s1_base_q <= '0;
            s1_next_q <= '0;
            s1_rem_q  <= '0;
            s1_sel_q  <= '0;
            s2_base_q <= '0;
            s2_prod_q <= '0;
            s2_sel_q  <= '0;
            o_data_q  <= '0;
            o_sel_q   <= '0;
        end else if (adv) begin
            vld_q <= {vld_q[2:1], xfer};
            if (xfer) begin
                s1_base_q <= tbl_q[rd_sel][idx_b];
                s1_next_q <= tbl_q[rd_sel][idx_n];
                s1_rem_q  <= bus.i_data[FRAC_W-1:0];
                s1_sel_q  <= bus.i_sel;
            end
            s2_base_q <= s1_base_q;
            s2_prod_q <= prod_d;
            s2_sel_q  <= s1_sel_q;
            o_data_q  <= y_d;
            o_sel_q   <= s2_sel_q;
        end
    end

    assign bus.i_ready = adv;
    assign bus.o_valid = vld_q[3];
    assign bus.o_data  = o_data_q;
    assign bus.o_sel   = o_sel_q;

`ifdef PWL_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    assign cnt_d = (vld_q[3] && bus.o_ready) ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign bus.o_count = cnt_q;
`else
    assign bus.o_count = '0;
`endif
endmodule

// File: doc/pwl_activation_pipe.md
Name: pwl_activation_pipe

Overview:
- Pipelined, parametrised piecewise-linear activation unit; the successor to the fixed 8-bit combinational LUT+interpolator activation.
- Holds N_TBL run-time-writable tables (table 0 = sigmoid, table 1 = tanh for the LSTM gates). Each sample selects its table.
- Valid/ready stream in and out, with 3-stage latency and full backpressure.
- Sits between a neuron's MAC/accumulator and the next layer.

Parameters:
- DATA_W, 8, width of signed input/output samples and table entries.
- ADDR_W, 4, index bits taken from i_data MSBs; FRAC_W = DATA_W-ADDR_W low bits are the interpolation fraction (must be 1..DATA_W-1).
- N_TBL, 2, number of tables.
- SEL_W, 1, width of the table-select fields (2^SEL_W >= N_TBL).

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-low reset.
- i_valid, in, 1, input sample valid.
- i_ready, out, 1, unit accepts a sample this cycle.
- i_data, in, DATA_W, signed activation input z.
- i_sel, in, SEL_W, table select for this sample.
- o_valid, out, 1, output valid.
- o_ready, in, 1, downstream accepts.
- o_data, out, DATA_W, signed activation result.
- o_sel, out, SEL_W, i_sel echoed alongside the result.
- tbl_we, in, 1, table write strobe.
- tbl_sel, in, SEL_W, table to write.
- tbl_addr, in, ADDR_W+1, entry index, 0..2^ADDR_W.
- tbl_data, in, DATA_W, signed entry value.
- o_count, out, 16, accepted-output count (see Optional Feature).

Behaviour:
- Reset (rst=0, async):
  - All stage-valid bits cleared; o_valid=0, o_data=0, o_sel=0, o_count=0.
  - All table entries cleared to 0.
  - Any in-flight samples are discarded.
- Tables: each table holds 2^ADDR_W+1 entries. Writes land on the clk edge when tbl_we=1. tbl_sel>=N_TBL or tbl_addr>2^ADDR_W is ignored.
- Indexing:
  - idx = i_data[DATA_W-1:FRAC_W], taken as unsigned. Negative z therefore maps to the upper indices, matching the existing table layout.
  - rem = i_data[FRAC_W-1:0], unsigned.
  - base = T[idx]; next = T[idx+1].
- Pipeline advance: adv = !o_valid | o_ready; i_ready = adv. A transfer occurs when i_valid & i_ready.
- S1, on transfer: register base, next, rem, sel and valid. When adv=1 with no transfer, S1 valid is cleared.
- S2: diff = next - base as signed DATA_W+1 bits; prod = diff * rem as signed DATA_W+FRAC_W+2 bits. Registered with valid and sel.
- S3: y = base + (prod >>> FRAC_W), arithmetic shift (floor). The result always lies between base and next, so it is truncated to DATA_W bits into o_data with no overflow possible. o_valid, o_sel are registered.
- Latency: exactly 3 cycles from transfer to o_valid when o_ready stays 1. Throughput is 1 sample/clk.
- Stall: when o_ready=0 and o_valid=1, every stage holds and i_ready=0. Pipeline bubbles are not compressed while stalled.
- Table reads happen only in the S1 capture cycle. A write to the same entry in that cycle is not seen; the old value is used. Writes affect only samples accepted on later cycles.
- i_sel>=N_TBL reads as table 0.
- rem=0 gives o_data=base exactly.

Optional Feature:
- Macro PWL_CNT_EN.
- Defined: o_count increments on each o_valid & o_ready cycle, wraps 0xFFFF->0, and resets to 0.
- Undefined: o_count is tied to 0 and no counter logic exists.

Test Plan:
- Reset, then write T0[2]=40, T0[3]=56. Send z=0x28, sel=0 with o_ready=1 -> o_data=48 on the 3rd cycle after transfer; o_sel=0.
- Write T1[5]=100, T1[6]=60. Send z=0x54, sel=1 -> diff=-40, prod=-160, o_data=90.
- Write T0[15]=-3, T0[16]=5. Send z=0xFF (idx 15, rem 15) -> -3 + floor(120/16)=4. Send z=0xF0 -> -3.
- Stream 8 back-to-back samples while holding o_ready=0 for cycles 4-6 -> i_ready=0 during the stall, no sample lost or duplicated, order preserved, o_data held stable.
- Write T0[2]=80 in the same cycle z=0x28 is accepted -> result uses old 40 (48). The next sample uses 80 (68).
- Assert rst mid-stream with 2 samples in flight -> o_valid=0 immediately, tables read 0 afterwards. With PWL_CNT_EN, o_count = 0 after reset and equals the number of handshakes afterwards.
